touch_adc_responder: RTL and testbench

- Cycle-level model of the resistive-touch ADC that the touchpad controller talks to: the responder end of the same serial link (DCLK/CS/DIN/DOUT/BUSY).
- Receives the controller's 8-bit command byte and asserts BUSY for one DCLK period. It then shifts back a 12-bit or 8-bit conversion result taken from parallel sample inputs.
- Used in simulation and as an on-FPGA loopback stand-in for the touch panel, so the touchpad controller and the TFT cursor path can be exercised without hardware.

---
 rtl/touch_adc_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_touch_adc_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_adc_responder.sv
// touch_adc_responder: responder end of the resistive-touch ADC serial link.
// Takes the command byte, pulses BUSY, then shifts back the selected sample.
module touch_adc_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int RESULT_BITS = 12
) (
  input  logic                   cclk,
  input  logic                   rstb,
  input  logic                   touch_clk,
  input  logic                   touch_csb,
  input  logic                   data_in,
  output logic                   data_out,
  output logic                   touch_busy,
  input  logic [RESULT_BITS-1:0] x_value,
  input  logic [RESULT_BITS-1:0] y_value,
  input  logic [RESULT_BITS-1:0] z_value,
  output logic [7:0]             last_cmd,
  output logic                   frame_done
);

  localparam int CW = $clog2(RESULT_BITS + 1);
  localparam logic [CW-1:0] NB_FULL = CW'(RESULT_BITS);
  localparam logic [CW-1:0] NB_HALF = CW'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_CONV,
    S_BUSY,
    S_SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic clk_prev_q, clk_prev_d;

  logic clk_s;
  logic csb_s;
  logic din_s;
  logic rise;
  logic fall;

  logic [6:0]             cmd_sr_q, cmd_sr_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             last_cmd_q, last_cmd_d;
  logic [RESULT_BITS-1:0] sample_q, sample_d;
  logic [CW-1:0]          nbits_q, nbits_d;
  logic [CW-1:0]          rem_q, rem_d;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [2:0]             chan;
  logic                   mode_8;
  logic [RESULT_BITS-1:0] raw;
  logic [RESULT_BITS-1:0] conv;

  // Next values for the input synchroniser chains
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], touch_clk};
    csb_sync_d = {csb_sync_q[SYNC_STAGES-2:0], touch_csb};
    din_sync_d = {din_sync_q[SYNC_STAGES-2:0], data_in};
    clk_s      = clk_sync_q[SYNC_STAGES-1];
    csb_s      = csb_sync_q[SYNC_STAGES-1];
    din_s      = din_sync_q[SYNC_STAGES-1];
    clk_prev_d = clk_s;
    rise       = clk_s & ~clk_prev_q;
    fall       = ~clk_s & clk_prev_q;
  end

  // Synchroniser flops; chip select resets to deselected
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      clk_sync_q <= '0;
      csb_sync_q <= '1;
      din_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      csb_sync_q <= csb_sync_d;
      din_sync_q <= din_sync_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  // Channel decode and width reduction of the sample to latch
  always_comb begin
    chan   = last_cmd_q[6:4];
    mode_8 = last_cmd_q[3];
    unique case (1'b1)
      (chan == 3'b101): raw = x_value;
      (chan == 3'b001): raw = y_value;
      (chan == 3'b011): raw = z_value;
      default:          raw = '0;
    endcase
    if (mode_8) conv = RESULT_BITS'(raw[RESULT_BITS-1 -: 8]);
    else        conv = raw;
  end

  // State register
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; deselect overrides any edge
  always_comb begin
    state_d = state_q;
    if (csb_s) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (rise && din_s) state_d = S_CMD;
        S_CMD:   if (rise && bit_cnt_q == 4'd7) state_d = S_CONV;
        S_CONV:  if (fall) state_d = S_BUSY;
        S_BUSY:  if (fall) state_d = S_SHIFT;
        S_SHIFT: if (fall && rem_q == '0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values per state
  always_comb begin
    cmd_sr_d   = cmd_sr_q;
    bit_cnt_d  = bit_cnt_q;
    last_cmd_d = last_cmd_q;
    sample_d   = sample_q;
    nbits_d    = nbits_q;
    rem_d      = rem_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (csb_s) begin
      cmd_sr_d  = '0;
      bit_cnt_d = '0;
      nbits_d   = '0;
      rem_d     = '0;
      dout_d    = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rise && din_s) begin
            cmd_sr_d  = 7'h01;
            bit_cnt_d = 4'd1;
          end
        end
        S_CMD: begin
          if (rise) begin
            cmd_sr_d  = {cmd_sr_q[5:0], din_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7)
              last_cmd_d = {cmd_sr_q, din_s};
          end
        end
        S_CONV: begin
          if (fall) begin
            busy_d   = 1'b1;
            dout_d   = 1'b0;
            sample_d = conv;
            nbits_d  = mode_8 ? NB_HALF : NB_FULL;
          end
        end
        S_BUSY: begin
          if (fall) begin
            busy_d = 1'b0;
            dout_d = sample_q[nbits_q - 1'b1];
            rem_d  = nbits_q - 1'b1;
          end
        end
        S_SHIFT: begin
          if (fall) begin
            if (rem_q != '0) begin
              dout_d = sample_q[rem_q - 1'b1];
              rem_d  = rem_q - 1'b1;
            end else begin
              dout_d    = 1'b0;
              done_d    = 1'b1;
              cmd_sr_d  = '0;
              bit_cnt_d = '0;
              nbits_d   = '0;
            end
          end
        end
        default: begin
          dout_d = 1'b0;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      cmd_sr_q   <= '0;
      bit_cnt_q  <= '0;
      last_cmd_q <= '0;
      sample_q   <= '0;
      nbits_q    <= '0;
      rem_q      <= '0;
      dout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cmd_sr_q   <= cmd_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      last_cmd_q <= last_cmd_d;
      sample_q   <= sample_d;
      nbits_q    <= nbits_d;
      rem_q      <= rem_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Drive ports straight from registers
  always_comb begin
    data_out   = dout_q;
    touch_busy = busy_q;
    last_cmd   = last_cmd_q;
    frame_done = done_q;
  end

endmodule

// File: tb/tb_touch_adc_responder.sv
// tb_touch_adc_responder: drives the controller side of the serial link
// and checks returned words against a behavioural ADC model.
`timescale 1ns/1ps
module tb_touch_adc_responder;

  localparam int SS   = 2;
  localparam int HALF = 500;
  localparam int BUSY_CYC = (2 * HALF) / 10;

  logic        cclk = 1'b0;
  logic        rstb = 1'b0;
  logic        touch_clk = 1'b0;
  logic        touch_csb = 1'b1;
  logic        data_in = 1'b0;
  logic [11:0] x_value = '0;
  logic [11:0] y_value = '0;
  logic [11:0] z_value = '0;
  logic        data_out;
  logic        touch_busy;
  logic [7:0]  last_cmd;
  logic        frame_done;

  int vec = 0;
  int err = 0;
  int busy_cyc = 0;
  int done_cnt = 0;

  touch_adc_responder #(.SYNC_STAGES(SS), .RESULT_BITS(12)) dut (
    .cclk(cclk), .rstb(rstb),
    .touch_clk(touch_clk), .touch_csb(touch_csb),
    .data_in(data_in), .data_out(data_out),
    .touch_busy(touch_busy),
    .x_value(x_value), .y_value(y_value), .z_value(z_value),
    .last_cmd(last_cmd), .frame_done(frame_done)
  );

  always #5 cclk = ~cclk;

  always @(posedge cclk) begin
    if (touch_busy) busy_cyc <= busy_cyc + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  // Behavioural ADC: channel pick, 8-bit mode keeps the top byte
  function automatic logic [11:0] ref_word(input logic [7:0] cmd,
      input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    logic [11:0] v;
    case (cmd[6:4])
      3'd5:    v = x;
      3'd1:    v = y;
      3'd3:    v = z;
      default: v = 12'h000;
    endcase
    if (cmd[3]) v = v >> 4;
    return v;
  endfunction

  function automatic int ref_bits(input logic [7:0] cmd);
    return cmd[3] ? 8 : 12;
  endfunction

  task automatic dclk(input logic din);
    data_in = din;
    #HALF;
    touch_clk = 1'b1;
    #HALF;
    touch_clk = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input int lz);
    @(negedge cclk);
    touch_csb = 1'b0;
    #HALF;
    repeat (lz) dclk(1'b0);
    for (int i = 7; i >= 0; i--) dclk(cmd[i]);
  endtask

  // Clocks one busy period plus n result bits, sampling just before rises
  task automatic read_result(input int n, input int chg_at,
      input logic [11:0] chg_val,
      output logic [11:0] word, output logic busy0);
    word  = '0;
    busy0 = 1'b0;
    data_in = 1'b0;
    for (int i = 0; i <= n; i++) begin
      #HALF;
      if (i == 0) busy0 = touch_busy;
      else        word  = {word[10:0], data_out};
      if (i == chg_at) x_value = chg_val;
      touch_clk = 1'b1;
      #HALF;
      touch_clk = 1'b0;
    end
    #HALF;
  endtask

  task automatic end_frame();
    touch_csb = 1'b1;
    #(2 * HALF);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #23;
    vec++;
    if (data_out !== 1'b0 || touch_busy !== 1'b0 || frame_done !== 1'b0) begin
      err++;
      $display("FAIL reset_outs: got dout=%b busy=%b done=%b expected 0 0 0",
               data_out, touch_busy, frame_done);
    end
    vec++;
    if (last_cmd !== 8'h00) begin
      err++;
      $display("FAIL reset_last_cmd: got %h expected 00", last_cmd);
    end
    @(negedge cclk);
    rstb = 1'b1;
    #100;
  endtask

  task automatic test_x12();
    logic [11:0] w;
    logic bz;
    int b0, d0;
    x_value = 12'hA5C;
    b0 = busy_cyc;
    d0 = done_cnt;
    send_cmd(8'hD0, 0);
    read_result(12, -1, 12'h0, w, bz);
    vec++;
    if (w !== 12'hA5C) begin
      err++;
      $display("FAIL x12_word: got %h expected a5c", w);
    end
    vec++;
    if (bz !== 1'b1) begin
      err++;
      $display("FAIL x12_busy_at_rise: got %b expected 1", bz);
    end
    vec++;
    if (busy_cyc - b0 < BUSY_CYC - 1 || busy_cyc - b0 > BUSY_CYC + 1) begin
      err++;
      $display("FAIL x12_busy_len: got %0d cclk expected %0d",
               busy_cyc - b0, BUSY_CYC);
    end
    vec++;
    if (done_cnt - d0 !== 1) begin
      err++;
      $display("FAIL x12_done: got %0d pulses expected 1", done_cnt - d0);
    end
    vec++;
    if (last_cmd !== 8'hD0) begin
      err++;
      $display("FAIL x12_last_cmd: got %h expected d0", last_cmd);
    end
    vec++;
    if (data_out !== 1'b0) begin
      err++;
      $display("FAIL x12_dout_idle: got %b expected 0", data_out);
    end
    end_frame();
  endtask

  task automatic test_y8_leading_zeros();
    logic [11:0] w;
    logic bz;
    int d0;
    y_value = 12'h3F7;
    d0 = done_cnt;
    send_cmd(8'h98, 3);
    read_result(8, -1, 12'h0, w, bz);
    vec++;
    if (w !== 12'h03F) begin
      err++;
      $display("FAIL y8_word: got %h expected 03f", w);
    end
    vec++;
    if (data_out !== 1'b0 || done_cnt - d0 !== 1) begin
      err++;
      $display("FAIL y8_tail: got dout=%b done=%0d expected 0 1",
               data_out, done_cnt - d0);
    end
    end_frame();
  endtask

  task automatic test_z_unmapped();
    logic [11:0] w;
    logic bz;
    z_value = 12'h123;
    x_value = 12'hFFF;
    y_value = 12'hFFF;
    send_cmd(8'hB0, 0);
    read_result(12, -1, 12'h0, w, bz);
    vec++;
    if (w !== 12'h123 || bz !== 1'b1) begin
      err++;
      $display("FAIL z_word: got %h busy=%b expected 123 1", w, bz);
    end
    end_frame();
    send_cmd(8'hE0, 0);
    read_result(12, -1, 12'h0, w, bz);
    vec++;
    if (w !== 12'h000 || bz !== 1'b1) begin
      err++;
      $display("FAIL unmapped_word: got %h busy=%b expected 000 1", w, bz);
    end
    end_frame();
  endtask

  task automatic test_abort();
    logic [11:0] w;
    logic [11:0] xv;
    logic bz;
    int d0;
    x_value = 12'hFFF;
    d0 = done_cnt;
    send_cmd(8'hD0, 0);
    read_result(5, -1, 12'h0, w, bz);
    vec++;
    if (data_out !== 1'b1) begin
      err++;
      $display("FAIL abort_pre_dout: got %b expected 1", data_out);
    end
    @(negedge cclk);
    touch_csb = 1'b1;
    repeat (SS + 2) @(posedge cclk);
    #1;
    vec++;
    if (data_out !== 1'b0 || touch_busy !== 1'b0) begin
      err++;
      $display("FAIL abort_outs: got dout=%b busy=%b expected 0 0",
               data_out, touch_busy);
    end
    #(2 * HALF);
    vec++;
    if (done_cnt - d0 !== 0) begin
      err++;
      $display("FAIL abort_done: got %0d pulses expected 0", done_cnt - d0);
    end
    xv = 12'($urandom);
    x_value = xv;
    send_cmd(8'hD0, 0);
    read_result(12, -1, 12'h0, w, bz);
    vec++;
    if (w !== xv) begin
      err++;
      $display("FAIL abort_next_word: got %h expected %h", w, xv);
    end
    end_frame();
  endtask

  task automatic test_sample_stability();
    logic [11:0] w;
    logic bz;
    x_value = 12'h800;
    send_cmd(8'hD0, 0);
    read_result(12, 4, 12'h7FF, w, bz);
    vec++;
    if (w !== 12'h800) begin
      err++;
      $display("FAIL stable_word: got %h expected 800", w);
    end
    end_frame();
    send_cmd(8'hD0, 0);
    read_result(12, -1, 12'h0, w, bz);
    vec++;
    if (w !== 12'h7FF) begin
      err++;
      $display("FAIL stable_next: got %h expected 7ff", w);
    end
    end_frame();
  endtask

  task automatic test_async_reset();
    logic [11:0] w;
    logic bz;
    @(negedge cclk);
    touch_csb = 1'b0;
    #HALF;
    dclk(1'b1);
    dclk(1'b1);
    dclk(1'b0);
    @(negedge cclk);
    #1;
    rstb = 1'b0;
    #2;
    vec++;
    if (last_cmd !== 8'h00 || data_out !== 1'b0 ||
        touch_busy !== 1'b0 || frame_done !== 1'b0) begin
      err++;
      $display("FAIL async_reset: got cmd=%h dout=%b busy=%b done=%b expected 00 0 0 0",
               last_cmd, data_out, touch_busy, frame_done);
    end
    touch_csb = 1'b1;
    #50;
    rstb = 1'b1;
    #100;
    x_value = 12'h5A3;
    send_cmd(8'hD0, 0);
    read_result(12, -1, 12'h0, w, bz);
    vec++;
    if (w !== 12'h5A3 || last_cmd !== 8'hD0) begin
      err++;
      $display("FAIL post_reset_frame: got %h cmd=%h expected 5a3 d0",
               w, last_cmd);
    end
    end_frame();
  endtask

  task automatic test_random();
    logic [11:0] w;
    logic [11:0] exp_w;
    logic [7:0] cmd;
    logic bz;
    int n, lz, d0;
    for (int k = 0; k < 6; k++) begin
      x_value = 12'($urandom);
      y_value = 12'($urandom);
      z_value = 12'($urandom);
      cmd = {1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom)};
      lz = $urandom_range(0, 3);
      exp_w = ref_word(cmd, x_value, y_value, z_value);
      n = ref_bits(cmd);
      d0 = done_cnt;
      send_cmd(cmd, lz);
      read_result(n, -1, 12'h0, w, bz);
      vec++;
      if (w !== exp_w || bz !== 1'b1) begin
        err++;
        $display("FAIL rand_word[%0d] cmd=%h: got %h busy=%b expected %h 1",
                 k, cmd, w, bz, exp_w);
      end
      vec++;
      if (done_cnt - d0 !== 1 || last_cmd !== cmd) begin
        err++;
        $display("FAIL rand_frame[%0d]: got done=%0d cmd=%h expected 1 %h",
                 k, done_cnt - d0, last_cmd, cmd);
      end
      end_frame();
    end
  endtask

  initial begin
    test_reset();
    test_x12();
    test_y8_leading_zeros();
    test_z_unmapped();
    test_abort();
    test_sample_stability();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
